fp_output_stage: RTL and testbench

Buffered, parametrised FPU output stage. It packs the normalised lane results (integer significand, biased exponent, sign, NaN/Inf/error flags) of up to `LANES` operands into IEEE-754 single or double words. Packed words are queued in a `DEPTH`-entry FIFO behind valid/ready handshakes. The block sits between the FPU datapath and the register-file write port, and replaces the combinational two-lane packer.

---
 rtl/fp_output_stage.sv | 138 +++++++++++++
 tb/tb_fp_output_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_output_stage.sv
// Buffered FPU output stage: packs per-lane results into IEEE-754 single/double words and queues them in a DEPTH-entry FIFO.
// Optional macro FP_OUT_ERR_COUNT_EN builds a saturating error-transaction counter on err_count.
module fp_output_stage #(
    parameter int unsigned REG_SIZE = 64,
    parameter int unsigned INT_W    = 53,
    parameter int unsigned EXP_W    = 11,
    parameter int unsigned LANES    = 2,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        mode,
    input  logic [LANES*INT_W-1:0]      int_in,
    input  logic [LANES*EXP_W-1:0]      exp_in,
    input  logic [LANES-1:0]            sign_in,
    input  logic [LANES-1:0]            nan_in,
    input  logic [LANES-1:0]            inf_in,
    input  logic [LANES-1:0]            err_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*REG_SIZE-1:0]   out_word,
    output logic                        out_err,
    output logic [15:0]                 err_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = LANES * REG_SIZE;

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] wordMem [DEPTH];
    logic [DEPTH-1:0]  errMem;

    logic [WORD_W-1:0] packedWord;
    logic [63:0]       laneWord;
    logic [INT_W-1:0]  laneInt;
    logic [EXP_W-1:0]  laneExp;
    logic              anyErr;
    logic              full;
    logic              empty;
    logic              doPush;
    logic              doPop;

    // Only the IEEE field slices of the significand and exponent are packed.
    logic unusedBits;
    assign unusedBits = ^{int_in, exp_in};

    // Per-lane packer, priority err > nan > inf > normal.
    always_comb begin
        packedWord = '0;
        laneWord   = '0;
        laneInt    = '0;
        laneExp    = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            laneInt = int_in[k*INT_W +: INT_W];
            laneExp = exp_in[k*EXP_W +: EXP_W];
            if (err_in[k]) begin
                laneWord = '0;
            end else if (nan_in[k]) begin
                laneWord = mode ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
            end else if (inf_in[k]) begin
                laneWord = mode ? {sign_in[k], 11'h7FF, 52'd0}
                                : {32'd0, sign_in[k], 8'hFF, 23'd0};
            end else begin
                laneWord = mode ? {sign_in[k], laneExp[10:0], laneInt[51:0]}
                                : {32'd0, sign_in[k], laneExp[7:0], laneInt[22:0]};
            end
            packedWord[k*REG_SIZE +: REG_SIZE] = REG_SIZE'(laneWord);
        end
    end

    assign anyErr = |err_in;
    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = in_valid && !full && !flush;
    assign doPop  = !empty && out_ready && !flush;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_word  = wordMem[rdPtr];
    assign out_err   = errMem[rdPtr] && !empty;

    // Pointer and occupancy state; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            wordMem[wrPtr] <= packedWord;
            errMem[wrPtr]  <= anyErr;
        end
    end

`ifdef FP_OUT_ERR_COUNT_EN
    logic [15:0] errCnt;

    // Counts transactions that actually enter the FIFO; flushed pushes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt <= '0;
        end else if (doPush && anyErr && (errCnt != 16'hFFFF)) begin
            errCnt <= errCnt + 16'd1;
        end
    end

    assign err_count = errCnt;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_fp_output_stage.sv
// Self-checking bench for fp_output_stage: table-driven vectors feeding a scoreboard, plus backpressure, flush and reset sequences.
module tb_fp_output_stage;

    localparam int unsigned REG_SIZE = 64;
    localparam int unsigned INT_W    = 53;
    localparam int unsigned EXP_W    = 11;
    localparam int unsigned LANES    = 2;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned WORD_W   = LANES * REG_SIZE;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic                      mode;
    logic [LANES*INT_W-1:0]    int_in;
    logic [LANES*EXP_W-1:0]    exp_in;
    logic [LANES-1:0]          sign_in;
    logic [LANES-1:0]          nan_in;
    logic [LANES-1:0]          inf_in;
    logic [LANES-1:0]          err_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_W-1:0]         out_word;
    logic                      out_err;
    logic [15:0]               err_count;

    fp_output_stage #(
        .REG_SIZE(REG_SIZE), .INT_W(INT_W), .EXP_W(EXP_W), .LANES(LANES), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .int_in(int_in), .exp_in(exp_in), .sign_in(sign_in),
        .nan_in(nan_in), .inf_in(inf_in), .err_in(err_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             mode;
        logic [INT_W-1:0] int0;
        logic [INT_W-1:0] int1;
        logic [EXP_W-1:0] exp0;
        logic [EXP_W-1:0] exp1;
        logic [1:0]       sign;
        logic [1:0]       nan;
        logic [1:0]       inf;
        logic [1:0]       err;
        logic [63:0]      w0;
        logic [63:0]      w1;
        logic             e;
    } vec_t;

    typedef struct {
        logic [WORD_W-1:0] word;
        logic              err;
    } sb_t;

    vec_t vecs [7];
    sb_t  sb [$];
    int   nChecks = 0;
    int   nFail   = 0;
    int   mCount  = 0;
    int   mErr    = 0;

    function automatic void check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic logic [15:0] expErrCount();
`ifdef FP_OUT_ERR_COUNT_EN
        return 16'(mErr);
`else
        return 16'd0;
`endif
    endfunction

    task automatic drive(input int idx);
        mode    = vecs[idx].mode;
        int_in  = {vecs[idx].int1, vecs[idx].int0};
        exp_in  = {vecs[idx].exp1, vecs[idx].exp0};
        sign_in = vecs[idx].sign;
        nan_in  = vecs[idx].nan;
        inf_in  = vecs[idx].inf;
        err_in  = vecs[idx].err;
    endtask

    // One clock: drive, score the pending pop/push, clock, then check status outputs.
    task automatic step(input bit v, input int idx, input bit ordy, input bit fl);
        sb_t e;
        in_valid  = v;
        drive(idx);
        out_ready = ordy;
        flush     = fl;
        #1;
        if (!fl && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_word", out_word, e.word);
                check("out_err", WORD_W'(out_err), WORD_W'(e.err));
                mCount--;
            end
        end
        if (!fl && in_valid && in_ready) begin
            e.word = {vecs[idx].w1, vecs[idx].w0};
            e.err  = vecs[idx].e;
            sb.push_back(e);
            mCount++;
            if ((|vecs[idx].err) && mErr < 16'hFFFF) mErr++;
        end
        if (fl) begin
            sb.delete();
            mCount = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("out_valid", WORD_W'(out_valid), WORD_W'(mCount != 0));
        check("in_ready", WORD_W'(in_ready), WORD_W'(mCount < int'(DEPTH)));
        check("err_count", WORD_W'(err_count), WORD_W'(expErrCount()));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //        mode int0                 int1                 exp0     exp1     sign   nan    inf    err    w0                      w1                      e
        vecs[0] = '{1'b0, 53'hC00000,          53'h0,               11'h080, 11'h000, 2'b01, 2'b00, 2'b00, 2'b00, 64'h0000_0000_C040_0000, 64'h0,                  1'b0};
        vecs[1] = '{1'b1, 53'h0,               53'h18000000000000,  11'h000, 11'h400, 2'b00, 2'b00, 2'b00, 2'b00, 64'h0,                  64'h4008_0000_0000_0000, 1'b0};
        vecs[2] = '{1'b1, 53'h0,               53'h0,               11'h000, 11'h000, 2'b10, 2'b11, 2'b10, 2'b01, 64'h0,                  64'h7FF8_0000_0000_0000, 1'b1};
        vecs[3] = '{1'b0, 53'h123,             53'h456,             11'h011, 11'h022, 2'b11, 2'b01, 2'b10, 2'b00, 64'h0000_0000_7FC0_0000, 64'h0000_0000_FF80_0000, 1'b0};
        vecs[4] = '{1'b1, 53'h0,               53'h0,               11'h000, 11'h000, 2'b10, 2'b00, 2'b11, 2'b00, 64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 1'b0};
        vecs[5] = '{1'b0, 53'h1FFFFFFFFFFFFF,  53'h1FFFFFFFFFFFFF,  11'h7FF, 11'h7FF, 2'b10, 2'b00, 2'b00, 2'b10, 64'h0000_0000_7FFF_FFFF, 64'h0,                  1'b1};
        vecs[6] = '{1'b1, 53'h1FFFFFFFFFFFFF,  53'h10000000000001,  11'h7FE, 11'h3FF, 2'b10, 2'b00, 2'b00, 2'b00, 64'h7FEF_FFFF_FFFF_FFFF, 64'hBFF0_0000_0000_0001, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(0);
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", WORD_W'(out_valid), 0);
        check("rst_in_ready", WORD_W'(in_ready), 1);
        check("rst_out_err", WORD_W'(out_err), 0);
        check("rst_err_count", WORD_W'(err_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors back-to-back with the consumer always ready.
        for (int i = 0; i < 7; i++) step(1'b1, i, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        check("table_drained", WORD_W'(sb.size()), 0);

        // Backpressure: five offers into a stalled FIFO, then drain in order.
        for (int i = 0; i < 5; i++) step(1'b1, i, 1'b0, 1'b0);
        check("full_accepts", WORD_W'(sb.size()), WORD_W'(DEPTH));
        step(1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < int'(DEPTH) + 2; i++) step(1'b0, 0, 1'b1, 1'b0);
        check("full_drained", WORD_W'(sb.size()), 0);

        // Flush with a simultaneous push drops everything.
        step(1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 2, 1'b0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b1);
        check("flush_empty", WORD_W'(out_valid), 0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 6, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries queued.
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 5, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_rst_out_valid", WORD_W'(out_valid), 0);
        check("amid_rst_in_ready", WORD_W'(in_ready), 1);
        check("amid_rst_err_count", WORD_W'(err_count), 0);
        sb.delete();
        mCount = 0;
        mErr   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        check("final_drained", WORD_W'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
